// File: rtl/issue_decode_multi.sv
// N-way in-order issue/decode stage: decodes up to ISSUE_W fetched instructions per cycle,
// routes them to the ALU or LD/ST reservation station under credit control, halts on illegal ops.
module issue_decode_multi #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned ISSUE_W      = 2,
    parameter int unsigned ALU_CREDITS  = 8,
    parameter int unsigned LDST_CREDITS = 4,
    localparam int unsigned CW          = $clog2(ISSUE_W + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [ISSUE_W-1:0]      fetch_valid,
    input  logic [ISSUE_W*XLEN-1:0] fetch_instr,
    input  logic [ISSUE_W*XLEN-1:0] fetch_pc,
    output logic [CW-1:0]           fetch_take,
    input  logic [CW-1:0]           alu_rel,
    input  logic [CW-1:0]           ldst_rel,
    output logic [ISSUE_W-1:0]      iss_valid,
    output logic [ISSUE_W-1:0]      iss_ldst,
    output logic [ISSUE_W*4-1:0]    iss_op,
    output logic [ISSUE_W*7-1:0]    iss_opc,
    output logic [ISSUE_W*5-1:0]    iss_rd,
    output logic [ISSUE_W*5-1:0]    iss_rs1,
    output logic [ISSUE_W*5-1:0]    iss_rs2,
    output logic [ISSUE_W-1:0]      iss_use_rd,
    output logic [ISSUE_W-1:0]      iss_use_rs1,
    output logic [ISSUE_W-1:0]      iss_use_rs2,
    output logic [ISSUE_W*XLEN-1:0] iss_imm,
    output logic [ISSUE_W*XLEN-1:0] iss_pc,
    output logic                    illegal,
    output logic [XLEN-1:0]         illegal_pc
);

    // Counter widths leave headroom for a full-scale release on top of the reset value.
    localparam int unsigned AW = $clog2(ALU_CREDITS + (1 << CW) + 1);
    localparam int unsigned LW = $clog2(LDST_CREDITS + (1 << CW) + 1);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpOp     = 7'b0110011;

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    state_e state_q, state_d;

    logic [ISSUE_W-1:0]           dec_legal;
    logic [ISSUE_W-1:0]           dec_ldst;
    logic [ISSUE_W-1:0]           dec_urd;
    logic [ISSUE_W-1:0]           dec_urs1;
    logic [ISSUE_W-1:0]           dec_urs2;
    logic [ISSUE_W-1:0][XLEN-1:0] dec_imm;
    logic [ISSUE_W-1:0][3:0]      dec_op;

    for (genvar g = 0; g < ISSUE_W; g++) begin : g_dec
        logic [XLEN-1:0]    ins;
        logic [6:0]         opc;
        logic               legal;
        logic               ldst;
        logic               urd;
        logic               urs1;
        logic               urs2;
        logic               qual;
        logic signed [31:0] imm32;

        assign ins = fetch_instr[g*XLEN +: XLEN];
        assign opc = ins[6:0];

        always_comb begin
            legal = 1'b1;
            ldst  = 1'b0;
            urd   = 1'b1;
            urs1  = 1'b0;
            urs2  = 1'b0;
            imm32 = '0;
            case (opc)
                OpLoad: begin
                    ldst  = 1'b1;
                    urs1  = 1'b1;
                    imm32 = {{20{ins[31]}}, ins[31:20]};
                end
                OpStore: begin
                    ldst  = 1'b1;
                    urd   = 1'b0;
                    urs1  = 1'b1;
                    urs2  = 1'b1;
                    imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
                end
                OpLui, OpAuipc: begin
                    imm32 = {ins[31:12], 12'b0};
                end
                OpJal: begin
                    imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
                end
                OpJalr: begin
                    urs1  = 1'b1;
                    imm32 = {{20{ins[31]}}, ins[31:20]};
                end
                OpBranch: begin
                    urd   = 1'b0;
                    urs1  = 1'b1;
                    urs2  = 1'b1;
                    imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                end
                OpImm: begin
                    urs1  = 1'b1;
                    imm32 = {{20{ins[31]}}, ins[31:20]};
                end
                OpOp: begin
                    urs1 = 1'b1;
                    urs2 = 1'b1;
                end
                default: begin
                    legal = 1'b0;
                    urd   = 1'b0;
                end
            endcase
            if (ins[11:7] == 5'd0) begin
                urd = 1'b0;
            end
        end

        // funct7[5] only qualifies R-type ops and the shift-right immediates.
        assign qual = ins[30] & ((opc == OpOp) | ((opc == OpImm) & (ins[14:12] == 3'b101)));

        assign dec_legal[g] = legal;
        assign dec_ldst[g]  = ldst;
        assign dec_urd[g]   = urd;
        assign dec_urs1[g]  = urs1;
        assign dec_urs2[g]  = urs2;
        assign dec_imm[g]   = XLEN'(imm32);
        assign dec_op[g]    = {qual, ins[14:12]};
    end

    logic [AW-1:0]      alu_cnt_q, alu_cnt_d, alu_used, alu_sum;
    logic [LW-1:0]      ldst_cnt_q, ldst_cnt_d, ldst_used, ldst_sum;
    logic [ISSUE_W-1:0] issue;
    logic [CW-1:0]      take;
    logic               halt_hit;
    logic [XLEN-1:0]    halt_pc;
    logic               go;

    // In-order issue scan: the first slot that cannot go blocks every younger slot.
    always_comb begin
        go        = (state_q == StRun) && !flush;
        issue     = '0;
        take      = '0;
        alu_used  = '0;
        ldst_used = '0;
        halt_hit  = 1'b0;
        halt_pc   = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            if (go) begin
                if (!fetch_valid[i]) begin
                    go = 1'b0;
                end else if (!dec_legal[i]) begin
                    go       = 1'b0;
                    halt_hit = 1'b1;
                    halt_pc  = fetch_pc[i*XLEN +: XLEN];
                end else if (dec_ldst[i] ? (ldst_used >= ldst_cnt_q)
                                         : (alu_used >= alu_cnt_q)) begin
                    go = 1'b0;
                end else begin
                    issue[i] = 1'b1;
                    take     = take + CW'(1);
                    if (dec_ldst[i]) begin
                        ldst_used = ldst_used + LW'(1);
                    end else begin
                        alu_used = alu_used + AW'(1);
                    end
                end
            end
        end
    end

    assign fetch_take = take;

    assign alu_sum    = alu_cnt_q - alu_used + AW'(alu_rel);
    assign ldst_sum   = ldst_cnt_q - ldst_used + LW'(ldst_rel);
    assign alu_cnt_d  = (alu_sum > AW'(ALU_CREDITS)) ? AW'(ALU_CREDITS) : alu_sum;
    assign ldst_cnt_d = (ldst_sum > LW'(LDST_CREDITS)) ? LW'(LDST_CREDITS) : ldst_sum;

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = StRun;
        end else if (halt_hit) begin
            state_d = StHalt;
        end
    end

    logic [ISSUE_W*4-1:0]    op_d;
    logic [ISSUE_W*7-1:0]    opc_d;
    logic [ISSUE_W*5-1:0]    rd_d, rs1_d, rs2_d;
    logic [ISSUE_W-1:0]      ldst_d, use_rd_d, use_rs1_d, use_rs2_d;
    logic [ISSUE_W*XLEN-1:0] imm_d, pc_d;

    // Slots that do not issue present all-zero fields downstream.
    always_comb begin
        op_d      = '0;
        opc_d     = '0;
        rd_d      = '0;
        rs1_d     = '0;
        rs2_d     = '0;
        ldst_d    = '0;
        use_rd_d  = '0;
        use_rs1_d = '0;
        use_rs2_d = '0;
        imm_d     = '0;
        pc_d      = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            if (issue[i]) begin
                op_d[i*4 +: 4]       = dec_op[i];
                opc_d[i*7 +: 7]      = fetch_instr[i*XLEN +: 7];
                rd_d[i*5 +: 5]       = fetch_instr[i*XLEN + 7 +: 5];
                rs1_d[i*5 +: 5]      = fetch_instr[i*XLEN + 15 +: 5];
                rs2_d[i*5 +: 5]      = fetch_instr[i*XLEN + 20 +: 5];
                ldst_d[i]            = dec_ldst[i];
                use_rd_d[i]          = dec_urd[i];
                use_rs1_d[i]         = dec_urs1[i];
                use_rs2_d[i]         = dec_urs2[i];
                imm_d[i*XLEN +: XLEN] = dec_imm[i];
                pc_d[i*XLEN +: XLEN]  = fetch_pc[i*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            alu_cnt_q   <= AW'(ALU_CREDITS);
            ldst_cnt_q  <= LW'(LDST_CREDITS);
            illegal_pc  <= '0;
            iss_valid   <= '0;
            iss_ldst    <= '0;
            iss_op      <= '0;
            iss_opc     <= '0;
            iss_rd      <= '0;
            iss_rs1     <= '0;
            iss_rs2     <= '0;
            iss_use_rd  <= '0;
            iss_use_rs1 <= '0;
            iss_use_rs2 <= '0;
            iss_imm     <= '0;
            iss_pc      <= '0;
        end else begin
            state_q     <= state_d;
            alu_cnt_q   <= alu_cnt_d;
            ldst_cnt_q  <= ldst_cnt_d;
            if (halt_hit) begin
                illegal_pc <= halt_pc;
            end
            iss_valid   <= issue;
            iss_ldst    <= ldst_d;
            iss_op      <= op_d;
            iss_opc     <= opc_d;
            iss_rd      <= rd_d;
            iss_rs1     <= rs1_d;
            iss_rs2     <= rs2_d;
            iss_use_rd  <= use_rd_d;
            iss_use_rs1 <= use_rs1_d;
            iss_use_rs2 <= use_rs2_d;
            iss_imm     <= imm_d;
            iss_pc      <= pc_d;
        end
    end

    assign illegal = (state_q == StHalt);

    // A release beyond the RS size means the RS and this stage disagree on occupancy.
    alu_credit_ovf: assert property (@(posedge clk) disable iff (rst)
        alu_sum <= AW'(ALU_CREDITS));
    ldst_credit_ovf: assert property (@(posedge clk) disable iff (rst)
        ldst_sum <= LW'(LDST_CREDITS));

endmodule

// File: doc/issue_decode_multi.md
Name: issue_decode_multi

Overview:
Parametrised N-way in-order issue/decode stage for the out-of-order core. Each cycle it takes up to ISSUE_W fetched instructions and decodes them into operand, register-tag and immediate fields. It routes each one to the ALU reservation station or the load/store reservation station. It tracks free RS entries with credit counters, and halts on an illegal opcode until the pipeline is flushed.

Parameters:
XLEN, 32, datapath and instruction width
ISSUE_W, 2, issue slots per cycle (legal 1..4); slot 0 is oldest
ALU_CREDITS, 8, ALU RS entries, which is the reset value of the ALU credit counter
LDST_CREDITS, 4, LD/ST RS entries, which is the reset value of the LD/ST credit counter
CW, $clog2(ISSUE_W+1), width of the count ports (derived, not overridable)

Ports:
clk  in  1  core clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  pipeline flush (mispredict or trap); synchronous
fetch_valid  in  ISSUE_W  per-slot valid; contiguous from slot 0
fetch_instr  in  ISSUE_W*XLEN  instructions, slot i at [i*XLEN +: XLEN]
fetch_pc  in  ISSUE_W*XLEN  PC of each slot
fetch_take  out  CW  combinational count of slots consumed this cycle; fetch drops the oldest fetch_take slots
alu_rel  in  CW  ALU RS entries freed this cycle
ldst_rel  in  CW  LD/ST RS entries freed this cycle
iss_valid  out  ISSUE_W  registered per-slot issue valid
iss_ldst  out  ISSUE_W  1 = routed to the LD/ST RS, 0 = routed to the ALU RS
iss_op  out  ISSUE_W*4  {funct7[5] qualifier, funct3}
iss_opc  out  ISSUE_W*7  raw opcode
iss_rd, iss_rs1, iss_rs2  out  ISSUE_W*5 each  register addresses
iss_use_rd, iss_use_rs1, iss_use_rs2  out  ISSUE_W each  field is meaningful (rename/tag lookup required)
iss_imm  out  ISSUE_W*XLEN  sign-extended immediate
iss_pc  out  ISSUE_W*XLEN  PC of the slot
illegal  out  1  HALT state indicator
illegal_pc  out  XLEN  PC of the offending instruction

Behaviour:
- Reset values: all iss_* outputs 0; illegal = 0; illegal_pc = 0; state RUN; alu_cnt = ALU_CREDITS; ldst_cnt = LDST_CREDITS.
- States:
  - RUN: issuing normally.
  - HALT: entered on an illegal opcode. fetch_take = 0 and iss_valid = 0 next cycle. Left only by flush.
- Slot i issues when all of the following hold:
  - state is RUN and flush = 0;
  - fetch_valid[i] = 1 and every older slot issued this cycle;
  - the opcode is legal;
  - the target RS has credits remaining. The check uses the current counter minus the older same-cycle slots bound for that RS.
- Issue stops at the first slot that fails; later slots are never issued out of order. fetch_take = number of issued slots.
- Illegal opcode at the first failing slot: the slot is not consumed. Next cycle: state = HALT, illegal = 1, illegal_pc = that slot's PC. Older slots in the same cycle still issue.
- Legal opcodes and routing:
  - LOAD (0000011) and STORE (0100011) go to LD/ST.
  - LUI, AUIPC, JAL, JALR, BRANCH, OP-IMM and OP go to the ALU.
  - Every other opcode is illegal.
- Immediate formats:
  - I: LOAD, JALR, OP-IMM
  - S: STORE
  - B: BRANCH
  - U: LUI, AUIPC
  - J: JAL
  - OP: immediate is 0
- All immediates are sign-extended from instr[31] to XLEN.
- Field-use flags:
  - use_rd = 1 for all except STORE and BRANCH.
  - use_rs1 = 1 for JALR, BRANCH, LOAD, STORE, OP-IMM and OP.
  - use_rs2 = 1 for BRANCH, STORE and OP.
  - rd = x0 forces use_rd = 0.
- iss_op[3] = instr[30] for OP, and for OP-IMM with funct3 = 101; 0 otherwise.
- Latency: one cycle from a fetch slot being consumed to its iss_valid. Outputs are fully registered. No downstream ready signal; credits guarantee acceptance.
- Credits: cnt_next = cnt - issued_to_rs + rel.
  - Release does not bypass into the same-cycle issue check.
  - The counter saturates at its reset value. A release that would overflow triggers a simulation assertion.
- Flush:
  - Next cycle: iss_valid = 0, fetch_take = 0 in the flush cycle, state = RUN, illegal = 0.
  - Credit counters are not reset; they still apply the rel inputs in that cycle.
- An asynchronous rst mid-operation returns every register to its reset value immediately.

Test Plan:
- ISSUE_W=2, after reset, fetch_valid=11 with ADDI x1,x0,5 and LW x2,4(x1) -> fetch_take=2. Next cycle iss_valid=11, iss_ldst=10, iss_imm = 5 and 4, alu_cnt=7, ldst_cnt=3.
- Four back-to-back LW pairs with no ldst_rel -> fetch_take sequence 2,2,0. iss_valid=00 after the 4th LW. Then ldst_rel=1 -> fetch_take=1 the following cycle.
- Slot0 = ADD, slot1 = opcode 0001111 at PC 0x104 -> fetch_take=1. Next cycle illegal=1, illegal_pc=0x104. fetch_take stays 0 until flush; after flush, illegal=0.
- BEQ with imm -8 and JAL with imm +2048 -> iss_imm = 0xFFFFFFF8 and 0x00000800; use_rd=0 for BEQ, 1 for JAL.
- Assert rst while in HALT with alu_cnt=3 -> immediately illegal=0, iss_valid=0, alu_cnt=8 after release.
- SUB x3,x1,x2 and SRAI x4,x4,3 -> iss_op = 1000 and 1101 respectively.
